// File: rtl/tx_pkg.sv
// Shared types and line-level constants for the clk_tx-paced serial transmit path.
package tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/rise_detect.sv
// Registers the divided clock level and flags its rising edge as a one-cycle strobe.
module rise_detect (
  input  logic clk_rx,
  input  logic rst,
  input  logic clk_tx,
  output logic strobe
);

  logic clk_tx_q;

  always_ff @(posedge clk_rx) begin
    if (rst) clk_tx_q <= 1'b0;
    else     clk_tx_q <= clk_tx;
  end

  assign strobe = clk_tx & ~clk_tx_q;

endmodule

// File: rtl/tx_bit_serializer.sv
// Start/data/stop frame transmitter paced by clk_tx rising edges; LSB first.
// Build option: define TX_PARITY_EN to insert an even-parity bit before the stop bit.
//
// state  | meaning
// IDLE   | line high, waiting for a word
// START  | word latched, waiting for the strobe that drives the start bit
// DATA   | shifting out WIDTH data bits
// PARITY | driving the even-parity bit (TX_PARITY_EN only)
// STOP   | stop bit driven, then held for one full bit period
module tx_bit_serializer
  import tx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_rx,
  input  logic             rst,
  input  logic             clk_tx,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sdata,
  output logic             busy,
  output logic             frame_done
);

  localparam int CW = $clog2(WIDTH + 1);

  tx_state_t        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             sdata_q, sdata_d;
  logic             done_q, done_d;
  logic             stop_q, stop_d;
  logic             strobe;
`ifdef TX_PARITY_EN
  logic             par_q, par_d;
`endif

  rise_detect u_rise (
    .clk_rx (clk_rx),
    .rst    (rst),
    .clk_tx (clk_tx),
    .strobe (strobe)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    sdata_d   = sdata_q;
    done_d    = 1'b0;
    stop_d    = stop_q;
`ifdef TX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // a strobe in the accept cycle is deliberately not used for the frame
        if (in_valid) begin
          shift_d   = in_data;
          bit_cnt_d = '0;
          stop_d    = 1'b0;
          state_d   = ST_START;
`ifdef TX_PARITY_EN
          par_d     = ^in_data;
`endif
        end
      end
      ST_START: begin
        if (strobe) begin
          sdata_d = LINE_START;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (strobe) begin
          sdata_d   = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CW'(WIDTH - 1)) begin
`ifdef TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef TX_PARITY_EN
      ST_PARITY: begin
        if (strobe) begin
          sdata_d = par_q;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (strobe) begin
          if (!stop_q) begin
            sdata_d = LINE_IDLE;
            stop_d  = 1'b1;
          end else begin
            stop_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_rx) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      sdata_q   <= LINE_IDLE;
      done_q    <= 1'b0;
      stop_q    <= 1'b0;
`ifdef TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      sdata_q   <= sdata_d;
      done_q    <= done_d;
      stop_q    <= stop_d;
`ifdef TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign in_ready   = (state_q == ST_IDLE) & ~rst;
  assign busy       = (state_q != ST_IDLE);
  assign sdata      = sdata_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_tx_bit_serializer.sv
// Scoreboard bench for tx_bit_serializer: stimulus queues expected line bits, a monitor checks them per strobe.
module tb_tx_bit_serializer;

  localparam int WIDTH = 8;
`ifdef TX_PARITY_EN
  localparam int NB = WIDTH + 3;
`else
  localparam int NB = WIDTH + 2;
`endif

  logic             clk_rx = 1'b0;
  logic             rst = 1'b1;
  logic             clk_tx = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready, sdata, busy, frame_done;

  int n_cmp = 0;
  int n_bad = 0;
  bit exp_q[$];
  int bit_idx = 0;
  bit in_frame = 1'b0;
  bit prev_s = 1'b0;
  bit hold = 1'b1;
  bit cur_s, stb, fd_ok;
  int cyc = 0;
  int t0 = 0;
  int done_cnt = 0;
  bit tx_run = 1'b0;

  tx_bit_serializer #(.WIDTH(WIDTH)) dut (
    .clk_rx     (clk_rx),
    .rst        (rst),
    .clk_tx     (clk_tx),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sdata      (sdata),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk_rx = ~clk_rx;
  always @(negedge clk_rx) if (tx_run) clk_tx = ~clk_tx;

  task automatic chk(string name, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkn(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: one line bit per strobe once a frame is in progress
  always @(posedge clk_rx) begin
    #1;
    cyc++;
    fd_ok = 1'b0;
    cur_s = clk_tx;
    stb = cur_s & ~prev_s;
    prev_s = rst ? 1'b0 : cur_s;
    if (rst) begin
      in_frame = 1'b0;
      bit_idx = 0;
      exp_q.delete();
    end else begin
      if (in_frame && stb) begin
        if (bit_idx < NB) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL line_bit: got %0b expected <queue empty>", sdata);
          end else begin
            chk("line_bit", sdata, exp_q.pop_front());
          end
          if (bit_idx == 0) t0 = cyc;
          hold = sdata;
          bit_idx++;
        end else begin
          chk("frame_done", frame_done, 1'b1);
          chk("end_busy", busy, 1'b0);
          chkn("frame_len", cyc - t0, 2 * NB);
          in_frame = 1'b0;
          fd_ok = 1'b1;
          done_cnt++;
        end
      end else if (in_frame) begin
        chk("bit_hold", sdata, hold);
        chk("ready_low", in_ready, 1'b0);
      end
      if (frame_done && !fd_ok) chk("spurious_done", frame_done, 1'b0);
      if (!in_frame && busy) begin
        in_frame = 1'b1;
        bit_idx = 0;
        hold = 1'b1;
      end
    end
  end

  task automatic push_frame(logic [7:0] w, bit p);
    exp_q.push_back(1'b0);
    for (int i = 0; i < WIDTH; i++) exp_q.push_back(w[i]);
`ifdef TX_PARITY_EN
    exp_q.push_back(p);
`endif
    exp_q.push_back(1'b1);
  endtask

  // called at a negedge; returns at the negedge after the accept edge
  task automatic send(input logic [7:0] w, input bit p, input bit keep, output logic fd_seen);
    int n = 0;
    in_data = w;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk_rx);
      n++;
    end
    fd_seen = frame_done;
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
      in_valid = 1'b0;
      return;
    end
    push_frame(w, p);
    @(negedge clk_rx);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || in_frame) && n < 400) begin
      @(negedge clk_rx);
      n++;
    end
    if (n >= 400) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: busy=%0b after %0d cycles, required 0", busy, n);
    end
    @(negedge clk_rx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic fd;
    int n;
    repeat (3) @(negedge clk_rx);
    chk("rst_sdata", sdata, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    rst = 1'b0;
    tx_run = 1'b1;
    @(negedge clk_rx);
    chk("post_rst_in_ready", in_ready, 1'b1);

    // single frame 0xA5 (4 ones -> parity 0)
    send(8'hA5, 1'b0, 1'b0, fd);
    wait_idle();
    chkn("done_cnt_single", done_cnt, 1);

    // back-to-back with in_valid held high
    send(8'hFF, 1'b0, 1'b1, fd);
    send(8'h00, 1'b0, 1'b0, fd);
    chk("b2b_accept_at_done", fd, 1'b1);
    wait_idle();
    chkn("done_cnt_b2b", done_cnt, 3);

    // stalled clk_tx after accept
    tx_run = 1'b0;
    clk_tx = 1'b0;
    send(8'h96, 1'b0, 1'b0, fd);
    repeat (10) @(negedge clk_rx);
    chk("stall_sdata", sdata, 1'b1);
    chk("stall_busy", busy, 1'b1);
    tx_run = 1'b1;
    wait_idle();
    chkn("done_cnt_stall", done_cnt, 4);

    // input changes while busy are ignored
    send(8'h5A, 1'b0, 1'b0, fd);
    repeat (3) @(negedge clk_rx);
    in_data = 8'hFF;
    in_valid = 1'b1;
    repeat (6) @(negedge clk_rx);
    in_valid = 1'b0;
    in_data = 8'h00;
    wait_idle();
    chkn("done_cnt_ignore", done_cnt, 5);

    // reset during data bit 3 of 0x3C
    send(8'h3C, 1'b0, 1'b0, fd);
    n = 0;
    while (bit_idx != 5 && n < 100) begin
      @(negedge clk_rx);
      n++;
    end
    if (n >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL bit3_timeout: bit index %0d, required 5", bit_idx);
    end
    rst = 1'b1;
    @(negedge clk_rx);
    chk("midrst_sdata", sdata, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_frame_done", frame_done, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk_rx);
    chk("midrst_ready_after", in_ready, 1'b1);
    repeat (4) @(negedge clk_rx);
    chkn("done_cnt_midrst", done_cnt, 5);

    // recovery frame after the abort (0xC3 -> parity 0)
    send(8'hC3, 1'b0, 1'b0, fd);
    wait_idle();
    chkn("done_cnt_recover", done_cnt, 6);

`ifdef TX_PARITY_EN
    send(8'h07, 1'b1, 1'b0, fd);
    wait_idle();
    send(8'h03, 1'b0, 1'b0, fd);
    wait_idle();
    chkn("done_cnt_parity", done_cnt, 8);
`endif

    chkn("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
